// File: rtl/seven_segment_monitor.sv
// Watches a multiplexed active-low seven-segment bus, rebuilds the shown hex digits,
// pulses new_value after every digit has been refreshed, and keeps sticky timing/overlap flags.
module seven_segment_monitor #(
    parameter int NUM_DIGITS             = 8,
    parameter int CLK_FREQUENCY          = 100_000_000,
    parameter int MIN_SEGMENT_DISPLAY_US = 10_000,
    parameter int TOLERANCE_CLOCKS       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              segments,
    input  logic                    dp,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic                    err_clear,
    output logic                    new_value,
    output logic [4*NUM_DIGITS-1:0] display_val,
    output logic [NUM_DIGITS-1:0]   display_dp,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    timing_err,
    output logic                    overlap_err
);

    localparam int DIGIT_CLOCKS = CLK_FREQUENCY / 1_000_000 * MIN_SEGMENT_DISPLAY_US;
    localparam int DWELL_MAX    = DIGIT_CLOCKS + TOLERANCE_CLOCKS;
    localparam int DWELL_MIN    = (DIGIT_CLOCKS > TOLERANCE_CLOCKS) ? DIGIT_CLOCKS - TOLERANCE_CLOCKS : 0;
    localparam int CNT_W        = $clog2(DWELL_MAX + 2);

    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_SAT  = '1;
    localparam logic [CNT_W-1:0]      CNT_LO   = CNT_W'(DWELL_MIN);
    localparam logic [CNT_W-1:0]      CNT_HI   = CNT_W'(DWELL_MAX);
    localparam logic [NUM_DIGITS-1:0] ALL_DONE = '1;

    typedef enum logic [1:0] {IDLE, FIRST, TRACK, BLANKING} state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        dwell, dwell_n, dwell_inc;
    logic [NUM_DIGITS-1:0]   mask, mask_n, mask_upd;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic                    is_single, is_blank, is_multi, changed;
    logic                    done, timing_set, overlap_set;
    logic [4:0]              glyph;

    // Returns {legal, nibble}; segment bit 6 = A ... bit 0 = G, 0 = lit.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    assign glyph     = decode(segments);
    assign is_blank  = &anode;
    assign is_single = $onehot(~anode);
    assign is_multi  = !is_blank && !is_single;
    assign changed   = (anode != anode_d);
    assign dwell_inc = (dwell == CNT_SAT) ? dwell : dwell + CNT_ONE;
    assign mask_upd  = mask | ~anode_d;

    always_comb begin
        state_n     = state;
        dwell_n     = dwell;
        mask_n      = mask;
        done        = 1'b0;
        timing_set  = 1'b0;
        overlap_set = 1'b0;
        if (is_multi) begin
            // Overlap abandons the scan and the unfinished dwell.
            overlap_set = 1'b1;
            state_n     = IDLE;
            mask_n      = '0;
            dwell_n     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_single) begin
                        state_n = FIRST;
                        dwell_n = CNT_ONE;
                        mask_n  = '0;
                    end
                end
                FIRST, TRACK: begin
                    if (!changed) begin
                        dwell_n = dwell_inc;
                    end else begin
                        // The first dwell started mid-way, so only TRACK dwells are judged.
                        if (state == TRACK && (dwell < CNT_LO || dwell > CNT_HI))
                            timing_set = 1'b1;
                        dwell_n = CNT_ONE;
                        state_n = is_blank ? BLANKING : TRACK;
                        if (mask_upd == ALL_DONE) begin
                            done   = 1'b1;
                            mask_n = '0;
                        end else begin
                            mask_n = mask_upd;
                        end
                    end
                end
                BLANKING: begin
                    if (is_single) begin
                        state_n = TRACK;
                        dwell_n = CNT_ONE;
                    end else if (dwell_inc > CNT_HI) begin
                        state_n = IDLE;
                        mask_n  = '0;
                        dwell_n = '0;
                    end else begin
                        dwell_n = dwell_inc;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dwell       <= '0;
            mask        <= '0;
            anode_d     <= '1;
            new_value   <= 1'b0;
            display_val <= '0;
            display_dp  <= '0;
            digit_valid <= '0;
            timing_err  <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            state       <= state_n;
            dwell       <= dwell_n;
            mask        <= mask_n;
            anode_d     <= anode;
            new_value   <= done;
            // A new fault in the same cycle as err_clear keeps the flag set.
            timing_err  <= timing_set  | (timing_err  & ~err_clear);
            overlap_err <= overlap_set | (overlap_err & ~err_clear);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (is_single && !anode[i]) begin
                    display_val[4*i +: 4] <= glyph[3:0];
                    display_dp[i]         <= dp;
                    digit_valid[i]        <= glyph[4];
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Directed bench for seven_segment_monitor (4 digits, 10-clock dwell); completed scans are
// predicted into a queue and popped when new_value pulses.
module tb_seven_segment_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anode;
    logic        err_clear;
    logic        new_value;
    logic [15:0] display_val;
    logic [3:0]  display_dp;
    logic [3:0]  digit_valid;
    logic        timing_err;
    logic        overlap_err;

    seven_segment_monitor #(
        .NUM_DIGITS(4),
        .CLK_FREQUENCY(1_000_000),
        .MIN_SEGMENT_DISPLAY_US(10),
        .TOLERANCE_CLOCKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .segments(segments),
        .dp(dp),
        .anode(anode),
        .err_clear(err_clear),
        .new_value(new_value),
        .display_val(display_val),
        .display_dp(display_dp),
        .digit_valid(digit_valid),
        .timing_err(timing_err),
        .overlap_err(overlap_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  vld;
        logic [3:0]  dpm;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    logic [15:0] exp_val;
    logic [3:0]  exp_vld;
    logic [3:0]  exp_dp;
    logic [3:0]  val_tab [4] = '{4'h1, 4'h2, 4'h3, 4'hA};
    logic        dp_tab  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'h0: enc = 7'b0000001;
            4'h1: enc = 7'b1001111;
            4'h2: enc = 7'b0010010;
            4'h3: enc = 7'b0000110;
            4'h4: enc = 7'b1001100;
            4'h5: enc = 7'b0100100;
            4'h6: enc = 7'b0100000;
            4'h7: enc = 7'b0001111;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0000100;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b1100000;
            4'hC: enc = 7'b0110001;
            4'hD: enc = 7'b1000010;
            4'hE: enc = 7'b0110000;
            default: enc = 7'b0111000;
        endcase
    endfunction

    task automatic show(input int idx, input logic [6:0] seg, input logic [3:0] nib,
                        input logic v, input logic d, input int n);
        anode    = ~(4'b0001 << idx);
        segments = seg;
        dp       = d;
        exp_val[4*idx +: 4] = nib;
        exp_vld[idx]        = v;
        exp_dp[idx]         = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic dig(input int idx, input int n);
        show(idx, enc(val_tab[idx]), val_tab[idx], 1'b1, dp_tab[idx], n);
    endtask

    task automatic blank(input int n);
        anode    = 4'b1111;
        segments = 7'b1111111;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    task automatic push_scan();
        exp_t e;
        e.val = exp_val;
        e.vld = exp_vld;
        e.dpm = exp_dp;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_val"}, 32'(display_val), 32'h0);
        check({tag, "_vld"}, 32'(digit_valid), 32'h0);
        check({tag, "_dp"},  32'(display_dp),  32'h0);
        check({tag, "_nv"},  32'(new_value),   32'h0);
        check({tag, "_terr"}, 32'(timing_err), 32'h0);
        check({tag, "_oerr"}, 32'(overlap_err), 32'h0);
    endtask

    always @(negedge clk) begin
        if (new_value === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_new_value", 32'(new_value), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("scan_val", 32'(display_val), 32'(e.val));
                check("scan_vld", 32'(digit_valid), 32'(e.vld));
                check("scan_dp",  32'(display_dp),  32'(e.dpm));
            end
        end
    end

    initial begin
        rst = 1'b1; anode = 4'b1111; segments = 7'b1111111; dp = 1'b0; err_clear = 1'b0;
        exp_val = '0; exp_vld = '0; exp_dp = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Nominal round-robin scan
        dig(0, 10); dig(1, 10); dig(2, 10); dig(3, 10);
        push_scan(); dig(0, 10);
        check("first_scan_pending", 32'(sb.size()), 32'h0);
        dig(1, 10); dig(2, 10); dig(3, 10);
        push_scan(); dig(0, 10);
        check("nominal_val", 32'(display_val), 32'hA321);
        check("nominal_vld", 32'(digit_valid), 32'hF);
        check("nominal_dp",  32'(display_dp),  32'h2);
        check("nominal_terr", 32'(timing_err), 32'h0);
        check("nominal_oerr", 32'(overlap_err), 32'h0);

        // Long dwell, sticky flag, clear, then in-tolerance 8 and 12 dwells
        dig(1, 13); dig(2, 10);
        check("long_dwell_terr", 32'(timing_err), 32'h1);
        dig(3, 10); push_scan(); dig(0, 10);
        check("terr_sticky", 32'(timing_err), 32'h1);
        err_clear = 1'b1; dig(1, 1); err_clear = 1'b0;
        check("terr_cleared", 32'(timing_err), 32'h0);
        dig(1, 9); dig(2, 8); dig(3, 12); push_scan(); dig(0, 10);
        check("tolerance_edges_terr", 32'(timing_err), 32'h0);

        // Two anodes low for one cycle
        anode = 4'b1100;
        @(negedge clk);
        check("overlap_set", 32'(overlap_err), 32'h1);
        dig(1, 10); dig(2, 10); dig(3, 10); dig(0, 10);
        check("overlap_no_early_scan", 32'(sb.size()), 32'h0);
        push_scan(); dig(1, 10);
        pulse_clear();
        check("overlap_cleared", 32'(overlap_err), 32'h0);

        // Illegal glyph on digit 2
        show(2, 7'b1111111, 4'h0, 1'b0, 1'b0, 10);
        dig(3, 10); dig(0, 10); push_scan(); dig(1, 10);
        check("illegal_val", 32'(display_val), 32'hA021);
        check("illegal_vld", 32'(digit_valid), 32'hB);

        // Short blank gap keeps the scan going
        dig(2, 10); blank(5); dig(3, 10); dig(0, 10); push_scan(); dig(1, 10);
        check("short_gap_terr", 32'(timing_err), 32'h0);
        check("short_gap_pending", 32'(sb.size()), 32'h0);

        // Long blank gap drops back to idle
        dig(2, 10); blank(13);
        dig(3, 10); dig(0, 10); dig(1, 10); dig(2, 10);
        check("long_gap_no_scan", 32'(sb.size()), 32'h0);
        check("long_gap_terr", 32'(timing_err), 32'h0);
        check("long_gap_oerr", 32'(overlap_err), 32'h0);
        push_scan(); dig(3, 10);

        // Reset in the middle of a scan
        dig(0, 10); dig(1, 10);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        exp_val = '0; exp_vld = '0; exp_dp = '0;
        dig(2, 10); dig(3, 10); dig(0, 10); dig(1, 10);
        check("post_reset_no_early_scan", 32'(sb.size()), 32'h0);
        push_scan(); dig(2, 10);

        // Fault and err_clear in the same cycle
        dig(3, 13);
        err_clear = 1'b1; dig(0, 1); err_clear = 1'b0;
        check("terr_set_wins", 32'(timing_err), 32'h1);
        err_clear = 1'b1; anode = 4'b0011;
        @(negedge clk);
        err_clear = 1'b0;
        check("oerr_set_wins", 32'(overlap_err), 32'h1);
        dig(1, 2);
        pulse_clear();
        check("final_terr", 32'(timing_err), 32'h0);
        check("final_oerr", 32'(overlap_err), 32'h0);

        repeat (3) @(negedge clk);
        check("pending_scans", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
